cond_unit: RTL and testbench

CR16 condition-code unit: holds the processor status flags written by the ALU and evaluates the 4-bit CR16 condition field (Bcond/Jcond/Scond) against them. Sits between the ALU status output and the control FSM/PC logic. Provides a registered taken/not-taken result and an Scond write-back word one cycle after each evaluation request.

---
 rtl/cond_if.sv | 25 ++
 rtl/cond_unit.sv | 98 +++++++++
 tb/tb_cond_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cond_if.sv
// Port bundle between the ALU/control FSM and the CR16 condition-code unit.
interface cond_if #(
    parameter int P_WIDTH = 16
);
    logic               I_STATUS_WE;
    logic [4:0]         I_STATUS_MASK;
    logic [4:0]         I_STATUS;
    logic               I_EVAL_VALID;
    logic [3:0]         I_COND;
    logic               I_HOLD;
    logic [4:0]         O_FLAGS;
    logic               O_VALID;
    logic               O_TAKEN;
    logic [P_WIDTH-1:0] O_SCOND;

    modport master (
        output I_STATUS_WE, I_STATUS_MASK, I_STATUS, I_EVAL_VALID, I_COND, I_HOLD,
        input  O_FLAGS, O_VALID, O_TAKEN, O_SCOND
    );

    modport slave (
        input  I_STATUS_WE, I_STATUS_MASK, I_STATUS, I_EVAL_VALID, I_COND, I_HOLD,
        output O_FLAGS, O_VALID, O_TAKEN, O_SCOND
    );
endinterface

// File: rtl/cond_unit.sv
// CR16 condition-code unit: masked flag register plus registered Bcond/Jcond/Scond evaluation.
// Optional macro COND_BYPASS_EN: a request in the same cycle as a flag write sees the written flags.
//
// state    | meaning
// S_IDLE   | no result presented, O_VALID=0
// S_RESULT | result of the last accepted request presented, O_VALID=1
module cond_unit #(
    parameter int P_WIDTH = 16
) (
    input  logic   I_CLK,
    input  logic   I_RESET,
    cond_if.slave  bus
);
    localparam int F_C = 0;
    localparam int F_L = 1;
    localparam int F_F = 2;
    localparam int F_Z = 3;
    localparam int F_N = 4;

    typedef enum logic {
        S_IDLE,
        S_RESULT
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] flags_q, flags_d;
    logic       taken_q, taken_d;
    logic [4:0] eval_flags;

    function automatic logic cond_true(input logic [4:0] f, input logic [3:0] cond);
        logic r;
        r = 1'b0;
        case (cond)
            4'd0:  r = f[F_Z];
            4'd1:  r = !f[F_Z];
            4'd2:  r = f[F_C];
            4'd3:  r = !f[F_C];
            4'd4:  r = f[F_L];
            4'd5:  r = !f[F_L];
            4'd6:  r = f[F_N];
            4'd7:  r = !f[F_N];
            4'd8:  r = f[F_F];
            4'd9:  r = !f[F_F];
            4'd10: r = !f[F_L] && !f[F_Z];
            4'd11: r = f[F_L] || f[F_Z];
            4'd12: r = !f[F_N] && !f[F_Z];
            4'd13: r = f[F_N] || f[F_Z];
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        flags_d = flags_q;
        if (bus.I_STATUS_WE) begin
            flags_d = (flags_q & ~bus.I_STATUS_MASK) | (bus.I_STATUS & bus.I_STATUS_MASK);
        end
    end

`ifdef COND_BYPASS_EN
    assign eval_flags = flags_d;
`else
    assign eval_flags = flags_q;
`endif

    // Hold freezes the result path only; the flag register keeps tracking the ALU.
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        if (!bus.I_HOLD) begin
            if (bus.I_EVAL_VALID) begin
                state_d = S_RESULT;
                taken_d = cond_true(eval_flags, bus.I_COND);
            end else begin
                state_d = S_IDLE;
                taken_d = 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q <= S_IDLE;
            flags_q <= 5'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            taken_q <= taken_d;
        end
    end

    assign bus.O_FLAGS = flags_q;
    assign bus.O_VALID = (state_q == S_RESULT);
    assign bus.O_TAKEN = taken_q;
    assign bus.O_SCOND = {{(P_WIDTH-1){1'b0}}, taken_q};
endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus queues expected results, a negedge monitor checks them.
module tb_cond_unit;
    localparam int W = 16;

    logic clk;
    logic rst;
    cond_if #(.P_WIDTH(W)) bus ();

    cond_unit #(.P_WIDTH(W)) dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q[$];
    logic [4:0] mflags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reading of the CR16 condition table: flags {N,Z,F,L,C}.
    function automatic logic model(input logic [4:0] f, input logic [3:0] c);
        logic cf, lf, ff, zf, nf;
        {nf, zf, ff, lf, cf} = f;
        case (c)
            0: return zf;
            1: return ~zf;
            2: return cf;
            3: return ~cf;
            4: return lf;
            5: return ~lf;
            6: return nf;
            7: return ~nf;
            8: return ff;
            9: return ~ff;
            10: return ~(lf | zf);
            11: return lf | zf;
            12: return ~(nf | zf);
            13: return nf | zf;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.O_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got taken %b expected no result at %0t", bus.O_TAKEN, $time);
            end else begin
                logic e;
                e = exp_q.pop_front();
                chk("taken", {31'b0, bus.O_TAKEN}, {31'b0, e});
                chk("scond", {16'b0, bus.O_SCOND}, {31'b0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] mask, input logic [4:0] st,
                         input logic ev, input logic [3:0] cond, input logic hold);
        bus.I_STATUS_WE   = we;
        bus.I_STATUS_MASK = mask;
        bus.I_STATUS      = st;
        bus.I_EVAL_VALID  = ev;
        bus.I_COND        = cond;
        bus.I_HOLD        = hold;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, {31'b0, bus.O_VALID}, 32'd0);
        chk({name, "_taken"}, {31'b0, bus.O_TAKEN}, 32'd0);
        chk({name, "_scond"}, {16'b0, bus.O_SCOND}, 32'd0);
    endtask

    logic bypass;
    logic [4:0] prev, ef;

    initial begin
`ifdef COND_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        rst = 1'b1;
        drive(0, 5'h00, 5'h00, 0, 4'd0, 0);
        #2;
        chk_idle("reset");
        chk("reset_flags", {27'b0, bus.O_FLAGS}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Z set, EQ taken, NE not taken
        drive(1, 5'h1f, 5'b01000, 0, 4'd0, 0);
        tick();
        chk("flags_z", {27'b0, bus.O_FLAGS}, 32'b01000);
        drive(0, 5'h1f, 5'h00, 1, 4'd0, 0); exp_q.push_back(1'b1);
        tick();
        drive(0, 5'h1f, 5'h00, 1, 4'd1, 0); exp_q.push_back(1'b0);
        tick();
        drive(0, 5'h00, 5'h00, 0, 4'd0, 0);
        tick();
        chk_idle("idle_after_eq");

        // masked write clears C only
        drive(1, 5'h1f, 5'b01001, 0, 4'd0, 0);
        tick();
        drive(1, 5'b00001, 5'b00000, 0, 4'd0, 0);
        tick();
        chk("flags_masked", {27'b0, bus.O_FLAGS}, 32'b01000);
        drive(0, 5'h1f, 5'h1f, 1, 4'd11, 0); exp_q.push_back(1'b1);
        tick();
        drive(0, 5'h1f, 5'h1f, 1, 4'd10, 0); exp_q.push_back(1'b0);
        tick();
        drive(0, 5'h00, 5'h1f, 0, 4'd0, 0);
        tick();
        chk("flags_we0", {27'b0, bus.O_FLAGS}, 32'b01000);

        // same-cycle write of N with GT request
        drive(1, 5'h1f, 5'h00, 0, 4'd0, 0);
        tick();
        drive(1, 5'h1f, 5'b10000, 1, 4'd6, 0); exp_q.push_back(bypass);
        tick();
        drive(0, 5'h00, 5'h00, 0, 4'd0, 0);
        chk("flags_n", {27'b0, bus.O_FLAGS}, 32'b10000);
        tick();

        // hold freezes result, flags still write
        drive(0, 5'h00, 5'h00, 1, 4'd14, 0); exp_q.push_back(1'b1);
        tick();
        drive(1, 5'b00100, 5'b00100, 1, 4'd15, 1); exp_q.push_back(1'b1);
        tick();
        drive(0, 5'h00, 5'h00, 1, 4'd15, 1); exp_q.push_back(1'b1);
        tick();
        chk("flags_hold", {27'b0, bus.O_FLAGS}, 32'b10100);
        drive(0, 5'h00, 5'h00, 1, 4'd15, 1); exp_q.push_back(1'b1);
        tick();
        drive(0, 5'h00, 5'h00, 0, 4'd15, 0);
        tick();
        chk_idle("hold_release");

        // sweep 32 flag values x 16 codes back-to-back
        prev = 5'b10100;
        for (int v = 0; v < 32; v++) begin
            for (int c = 0; c < 16; c++) begin
                ef = bypass ? 5'(v) : prev;
                drive(1, 5'h1f, 5'(v), 1, 4'(c), 0);
                exp_q.push_back(model(ef, 4'(c)));
                tick();
                prev = 5'(v);
            end
        end
        chk("sweep_flags", {27'b0, bus.O_FLAGS}, 32'h1f);

        // async reset mid-evaluation
        @(negedge clk);
        #1;
        chk("pre_reset_valid", {31'b0, bus.O_VALID}, 32'd1);
        rst = 1'b1;
        #1;
        chk_idle("async_reset");
        chk("async_reset_flags", {27'b0, bus.O_FLAGS}, 32'd0);
        tick();
        drive(0, 5'h00, 5'h00, 0, 4'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk_idle("post_reset");
        drive(0, 5'h00, 5'h00, 1, 4'd14, 0); exp_q.push_back(1'b1);
        tick();
        drive(0, 5'h00, 5'h00, 0, 4'd0, 0);
        tick();
        chk_idle("final_idle");

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d results outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
